// File: rtl/hdmi_trace_decoder.sv
// Monitors an HDMI-style video stream. It rebuilds one trace sample per screen column,
// giving the first lit row of that column, and flags lines or frames with the wrong size.
module hdmi_trace_decoder #(
    parameter int WIDTH       = 1024,
    parameter int HEIGHT      = 512,
    parameter int LOG2_WIDTH  = 10,
    parameter int LOG2_HEIGHT = 9,
    parameter int VAL_RES     = 16,
    parameter int SYNC_POL    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   VDEn,
    input  logic                   hSync,
    input  logic                   vSync,
    input  logic [23:0]            pixel,
    input  logic                   arm,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LOG2_WIDTH-1:0]  out_col,
    output logic [LOG2_HEIGHT-1:0] out_row,
    output logic                   out_found,
    output logic [VAL_RES-1:0]     out_val,
    output logic                   line_err,
    output logic                   frame_err
);
    localparam int XW = LOG2_WIDTH + 1;
    localparam int YW = LOG2_HEIGHT + 1;
    localparam int SHIFT = VAL_RES - LOG2_HEIGHT;
    localparam logic [XW-1:0] X_FULL = XW'(WIDTH);
    localparam logic [YW-1:0] Y_FULL = YW'(HEIGHT);
    localparam logic [XW-1:0] X_MAX = '1;
    localparam logic [YW-1:0] Y_MAX = '1;
    localparam logic [LOG2_WIDTH-1:0] LAST_COL = LOG2_WIDTH'(WIDTH - 1);
    localparam logic [VAL_RES-1:0] TOP_ROW = VAL_RES'(HEIGHT - 1);
    localparam logic POL = 1'(SYNC_POL);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DUMP} state_t;
    state_t state, state_nxt;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic vs_prev, hs_prev, vde_prev, mid_line;
    logic vs_edge, hs_edge, vde_fall, lit, handshake, cap_we;
    logic [WIDTH-1:0] found;
    logic [LOG2_WIDTH-1:0] sweep_cnt;
    logic sweep_done;

    logic [YW-1:0] mem [WIDTH];
    logic [LOG2_WIDTH-1:0] mem_addr;
    logic mem_we;
    logic [YW-1:0] mem_wdata, mem_rdata;

    assign vs_edge   = (vSync == POL) && (vs_prev != POL);
    assign hs_edge   = (hSync == POL) && (hs_prev != POL);
    assign vde_fall  = vde_prev && !VDEn;
    assign lit       = |pixel;
    assign handshake = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign cap_we    = (state == CAPTURE) && VDEn && lit && !vs_edge &&
                       (x < X_FULL) && (y < Y_FULL) && !found[x[LOG2_WIDTH-1:0]];

    // Beam position. mid_line marks a line cut by vSync so its length is not judged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            vs_prev  <= POL;
            hs_prev  <= POL;
            vde_prev <= 1'b0;
            mid_line <= 1'b0;
        end else begin
            vs_prev  <= vSync;
            hs_prev  <= hSync;
            vde_prev <= VDEn;
            if (vs_edge) begin
                x        <= '0;
                y        <= '0;
                mid_line <= VDEn;
            end else if (vde_fall) begin
                x        <= '0;
                mid_line <= 1'b0;
                if (!mid_line && y != Y_MAX) y <= y + 1'b1;
            end else if (VDEn) begin
                if (x != X_MAX) x <= x + 1'b1;
            end else if (hs_edge) begin
                x <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm) state_nxt = WAIT_VS;
            WAIT_VS: if (vs_edge && sweep_done) state_nxt = CAPTURE;
            CAPTURE: if (vs_edge) state_nxt = DUMP;
            DUMP:    if (handshake && out_col == LAST_COL) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            found      <= '0;
            sweep_cnt  <= '0;
            sweep_done <= 1'b0;
            out_valid  <= 1'b0;
            out_col    <= '0;
        end else begin
            case (state)
                IDLE: if (arm) begin
                    line_err   <= 1'b0;
                    frame_err  <= 1'b0;
                    found      <= '0;
                    sweep_cnt  <= '0;
                    sweep_done <= 1'b0;
                end
                WAIT_VS: if (!sweep_done) begin
                    if (sweep_cnt == LAST_COL) sweep_done <= 1'b1;
                    else                       sweep_cnt  <= sweep_cnt + 1'b1;
                end
                CAPTURE: begin
                    if (cap_we) found[x[LOG2_WIDTH-1:0]] <= 1'b1;
                    if (vde_fall && !vs_edge && !mid_line && x != X_FULL) line_err <= 1'b1;
                    if (vs_edge && y != Y_FULL) frame_err <= 1'b1;
                end
                DUMP: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        if (out_col == LAST_COL) begin
                            out_valid <= 1'b0;
                            out_col   <= '0;
                        end else begin
                            out_col <= out_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // During DUMP the address runs one column ahead on a handshake, so the registered
    // read data always belongs to out_col and holds still while stalled.
    always_comb begin
        mem_addr  = out_col;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            WAIT_VS: if (!sweep_done) begin
                mem_addr = sweep_cnt;
                mem_we   = 1'b1;
            end
            CAPTURE: begin
                mem_addr  = x[LOG2_WIDTH-1:0];
                mem_we    = cap_we;
                mem_wdata = {1'b1, y[LOG2_HEIGHT-1:0]};
            end
            DUMP: if (handshake && out_col != LAST_COL) mem_addr = out_col + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    assign out_found = out_valid && mem_rdata[LOG2_HEIGHT];
    assign out_row   = out_valid ? mem_rdata[LOG2_HEIGHT-1:0] : '0;
    assign out_val   = out_found ? ((TOP_ROW - VAL_RES'(out_row)) << SHIFT) : '0;

endmodule

// File: doc/hdmi_trace_decoder.md
Name: hdmi_trace_decoder

Overview:
- Receiving end of the scope's HDMI video stream: watches the VDEn/hSync/vSync/pixel output of hdmiController on the pixel clock.
- Rebuilds the plotted trace, giving one sample per screen column: the row where the trace appears, plus the value estimate that row stands for.
- Also checks the frame geometry.
- Used as a self-checking sink in simulation and as an on-chip loopback monitor.

Parameters:
WIDTH, 1024, active pixels per line
HEIGHT, 512, active lines per frame
LOG2_WIDTH, 10, column index width
LOG2_HEIGHT, 9, row index width
VAL_RES, 16, reconstructed value width
SYNC_POL, 1, active level of hSync/vSync

Ports:
clk  in  1  pixel clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
VDEn  in  1  video data enable
hSync  in  1  horizontal sync
vSync  in  1  vertical sync
pixel  in  24  RGB pixel; lit = any bit set
arm  in  1  one-cycle pulse requesting capture of the next full frame
busy  out  1  high from accepted arm until the dump finishes
out_valid  out  1  result sample valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_col  out  LOG2_WIDTH  column index of the sample
out_row  out  LOG2_HEIGHT  first lit row in the column (0 = top)
out_found  out  1  column contained a lit pixel
out_val  out  VAL_RES  ((HEIGHT-1-out_row) << (VAL_RES-LOG2_HEIGHT)); 0 if !out_found
line_err  out  1  sticky: an active line had a pixel count != WIDTH
frame_err  out  1  sticky: the captured frame had a line count != HEIGHT

Behaviour:
- Reset (async):
  - State IDLE.
  - busy, out_valid, out_found, line_err, frame_err = 0.
  - out_col, out_row, out_val = 0.
  - Column memory contents are don't-care.
- Sync edges: a vSync edge is a transition from !SYNC_POL to SYNC_POL, registered one cycle. hSync edges are defined the same way.
- Counters (x = LOG2_WIDTH+1 bits, y = LOG2_HEIGHT+1 bits):
  - x increments on each VDEn=1 cycle.
  - On the VDEn falling edge: y increments, and x is compared with WIDTH, then cleared.
  - A vSync edge clears both x and y.
  - Counters saturate at their maximum and never wrap.
- State IDLE: arm → WAIT_VS. busy=1. Clear line_err and frame_err, and mark all WIDTH entries "not found". The clear is done by a WIDTH-cycle sweep during WAIT_VS; no capture occurs until the sweep is complete.
- State WAIT_VS: on a vSync edge with the sweep complete → CAPTURE.
- State CAPTURE:
  - For each VDEn=1 cycle with a lit pixel, x < WIDTH, y < HEIGHT, and the entry at x not yet found: store row y and set found. The first lit row in a column wins.
  - A line with x != WIDTH at VDEn fall sets line_err.
  - On the next vSync edge: set frame_err if y != HEIGHT, then → DUMP.
- State DUMP:
  - Present columns 0..WIDTH-1 in order.
  - Memory read latency is 1 cycle; out_valid rises no later than 2 cycles after entering DUMP.
  - out_* stay stable while out_valid & !out_ready.
  - On each handshake, advance to the next column. Back-to-back transfers are supported: with out_ready held high, one sample per cycle.
  - After column WIDTH-1 is accepted: out_valid=0, busy=0 → IDLE.
- Stream activity (VDEn/sync) during IDLE and DUMP is ignored. Frames arriving during DUMP are not captured.
- arm while busy is ignored.
- rst mid-capture or mid-dump: immediate return to IDLE; any partial result is discarded.
- A lit pixel and the VDEn falling edge in the same cycle: the pixel belongs to the ending line.
- A vSync edge while VDEn=1: treated as frame end. The partial line is not checked.
- Column memory: WIDTH × (LOG2_HEIGHT+1) bits, single-port, inferred as RAM. Capture writes, the WAIT_VS sweep writes, and DUMP reads are mutually exclusive by state.

Test Plan:
1. WIDTH=4, HEIGHT=4, SYNC_POL=1. Arm, then drive a frame with a diagonal trace (lit at (0,3),(1,2),(2,1),(3,0)) → 4 samples, rows 3,2,1,0, all found. out_val = 0x0000, 0x4000, 0x8000, 0xC000 (VAL_RES=16, LOG2_HEIGHT=2). line_err=0, frame_err=0.
2. Column 2 fully dark, and column 1 lit at rows 1 and 3 → col2 out_found=0, out_val=0. col1 out_row=1 (first lit row wins).
3. out_ready toggling 1,0,0,1 during the dump → each sample held stable while stalled. Exactly 4 handshakes with columns 0,1,2,3 in order. busy falls on the cycle after the last handshake.
4. Frame containing one line of 3 active pixels and only 3 active lines → line_err=1 and frame_err=1 after capture. Both clear on the next arm.
5. arm issued mid-frame → capture starts at the next vSync edge; the first partial frame is ignored. A second arm during DUMP is ignored.
6. rst asserted for 1 cycle mid-CAPTURE → all outputs are 0 immediately (asynchronous). The next arm plus a clean frame yields correct results.
